retire_unit: RTL and testbench



---
 rtl/retire_unit_pkg.sv | 42 ++++
 rtl/retire_unit_slot.sv | 29 ++
 rtl/retire_unit.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_retire_unit.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/retire_unit_pkg.sv
// ----------------------------------------------------------------------------
// retire_unit_pkg
// Shared definitions for the commit stage that sits after the reorder buffer:
//   RSTAG_NULL           ROB tag that marks an empty retire port
//   ZERO_REG             architectural register that is never written
//   HISTORY_BITS_DEFAULT default PHT index width
//   br_result_e          branch outcome encoding carried with each retire
//   retire_state_e       commit FSM states
//   slot_dec_t           per-slot decode produced by retire_slot
// ----------------------------------------------------------------------------
package retire_unit_pkg;

  localparam logic [7:0] RSTAG_NULL           = 8'hFF;
  localparam logic [4:0] ZERO_REG             = 5'd0;
  localparam int         HISTORY_BITS_DEFAULT = 8;

  // 2'b01 is reserved and is handled exactly like BR_NONE.
  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_RSVD = 2'b01,
    BR_NT   = 2'b10,
    BR_T    = 2'b11
  } br_result_e;

  typedef enum logic {
    RETIRE_RUN   = 1'b0,
    RETIRE_FLUSH = 1'b1
  } retire_state_e;

  typedef struct packed {
    logic valid;      // port carries a retiring instruction
    logic wr_en;      // valid and destination is not the zero register
    logic pht_en;     // valid and the instruction is a resolved branch
    logic pht_taken;  // resolved direction
  } slot_dec_t;

  // True for the two encodings that describe a real resolved branch.
  function automatic logic is_branch(input logic [1:0] br);
    return (br == BR_NT) || (br == BR_T);
  endfunction

endpackage

// File: rtl/retire_unit_slot.sv
// ----------------------------------------------------------------------------
// retire_slot
// Combinational decode of one ROB retire port. Cross-slot rules (slot 2
// depending on slot 1, squash, same-destination suppression) are applied in
// retire_unit, so this block only looks at its own port.
// Ports:
//   i_tag            ROB index of the retiring instruction (RSTAG_NULL = none)
//   i_dest           destination register
//   i_branch_result  branch outcome encoding
//   o_dec            decoded valid / write-enable / PHT-enable / PHT-taken
// ----------------------------------------------------------------------------
module retire_slot
  import retire_unit_pkg::*;
(
  input  logic [7:0] i_tag,
  input  logic [4:0] i_dest,
  input  logic [1:0] i_branch_result,
  output slot_dec_t  o_dec
);

  logic w_valid;

  assign w_valid         = (i_tag != RSTAG_NULL);
  assign o_dec.valid     = w_valid;
  assign o_dec.wr_en     = w_valid && (i_dest != ZERO_REG);
  assign o_dec.pht_en    = w_valid && is_branch(i_branch_result);
  assign o_dec.pht_taken = i_branch_result[0];

endmodule

// File: rtl/retire_unit.sv
// ----------------------------------------------------------------------------
// retire_unit
// Commit stage downstream of the reorder buffer. Accepts up to two retiring
// instructions per cycle, drives the register file write ports and the PHT
// update ports, and on a mispredicted branch redirects fetch and holds
// flush_out high for FLUSH_CYCLES cycles while ignoring the retire ports.
//
// Optional feature: define RETIRE_STATS_EN to add the commit statistics
// counters (stat_retired_out, stat_branches_out, stat_mispredicts_out).
//
// Ports:
//   clock, reset                 clock; asynchronous active-high reset
//   instN_*_in (N=1,2)           ROB retire port N (inst1 is the older one)
//   wrN_en/idx/data_out          register file write port N
//   phtN_en/index/taken_out      PHT update port N
//   redirect_valid/pc_out        one-cycle fetch redirect and its target
//   flush_out                    pipeline squash, FLUSH_CYCLES cycles long
//   retired_count_out            instructions committed this cycle
//   stat_*_out                   statistics (RETIRE_STATS_EN only)
//   dbg_state_out                current FSM state (RETIRE_RUN/RETIRE_FLUSH)
// All outputs are registered: retires sampled at edge T show up in cycle T+1.
// ----------------------------------------------------------------------------
module retire_unit
  import retire_unit_pkg::*;
#(
  parameter int HISTORY_BITS = HISTORY_BITS_DEFAULT,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                    clock,
  input  logic                    reset,

  input  logic [7:0]              inst1_retire_tag_in,
  input  logic [4:0]              inst1_dest_in,
  input  logic [63:0]             inst1_value_in,
  input  logic                    inst1_mispredicted_in,
  input  logic [1:0]              inst1_branch_result_in,
  input  logic [63:0]             inst1_NPC_in,
  input  logic [HISTORY_BITS-1:0] inst1_pht_index_in,

  input  logic [7:0]              inst2_retire_tag_in,
  input  logic [4:0]              inst2_dest_in,
  input  logic [63:0]             inst2_value_in,
  input  logic                    inst2_mispredicted_in,
  input  logic [1:0]              inst2_branch_result_in,
  input  logic [63:0]             inst2_NPC_in,
  input  logic [HISTORY_BITS-1:0] inst2_pht_index_in,

  output logic                    wr1_en_out,
  output logic [4:0]              wr1_idx_out,
  output logic [63:0]             wr1_data_out,
  output logic                    wr2_en_out,
  output logic [4:0]              wr2_idx_out,
  output logic [63:0]             wr2_data_out,

  output logic                    pht1_en_out,
  output logic [HISTORY_BITS-1:0] pht1_index_out,
  output logic                    pht1_taken_out,
  output logic                    pht2_en_out,
  output logic [HISTORY_BITS-1:0] pht2_index_out,
  output logic                    pht2_taken_out,

  output logic                    redirect_valid_out,
  output logic [63:0]             redirect_pc_out,
  output logic                    flush_out,
  output logic [1:0]              retired_count_out,
`ifdef RETIRE_STATS_EN
  output logic [63:0]             stat_retired_out,
  output logic [31:0]             stat_branches_out,
  output logic [31:0]             stat_mispredicts_out,
`endif
  output logic                    dbg_state_out
);

  // The down-counter is loaded with FLUSH_CYCLES-1 on entry to FLUSH and the
  // FSM leaves FLUSH on the edge where it reads 0, which gives exactly
  // FLUSH_CYCLES ignored input samples and FLUSH_CYCLES cycles of flush_out.
  localparam int                CNT_W     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  FLUSH_LD  = CNT_W'(FLUSH_CYCLES - 1);

  // --------------------------------------------------------------------------
  // Per-slot decode
  // --------------------------------------------------------------------------
  slot_dec_t w_dec1;
  slot_dec_t w_dec2;

  retire_slot u_slot1 (
    .i_tag           (inst1_retire_tag_in),
    .i_dest          (inst1_dest_in),
    .i_branch_result (inst1_branch_result_in),
    .o_dec           (w_dec1)
  );

  retire_slot u_slot2 (
    .i_tag           (inst2_retire_tag_in),
    .i_dest          (inst2_dest_in),
    .i_branch_result (inst2_branch_result_in),
    .o_dec           (w_dec2)
  );

  // --------------------------------------------------------------------------
  // Cross-slot commit rules (only meaningful while in RETIRE_RUN)
  // --------------------------------------------------------------------------
  logic        w_v1;
  logic        w_v2;
  logic        w_mp1;
  logic        w_mp2;
  logic        w_commit2;
  logic        w_wr1_en;
  logic        w_wr2_en;
  logic        w_pht1_en;
  logic        w_pht2_en;
  logic        w_mispredict;
  logic [63:0] w_redirect_pc;
  logic [1:0]  w_count;

  // inst2 is only considered when inst1 is present.
  assign w_v1      = w_dec1.valid;
  assign w_v2      = w_v1 && w_dec2.valid;

  // An inst1 mispredict kills the younger same-cycle retire.
  assign w_mp1     = w_v1 && inst1_mispredicted_in;
  assign w_commit2 = w_v2 && !w_mp1;
  assign w_mp2     = w_commit2 && inst2_mispredicted_in;

  assign w_wr2_en  = w_commit2 && w_dec2.wr_en;
  // Equal destinations in one cycle: only the younger write goes out.
  assign w_wr1_en  = w_dec1.wr_en && !(w_wr2_en && (inst1_dest_in == inst2_dest_in));

  assign w_pht1_en = w_dec1.pht_en;
  assign w_pht2_en = w_commit2 && w_dec2.pht_en;

  assign w_mispredict  = w_mp1 || w_mp2;
  assign w_redirect_pc = w_mp1 ? inst1_NPC_in : inst2_NPC_in;
  assign w_count       = {1'b0, w_v1} + {1'b0, w_commit2};

  // --------------------------------------------------------------------------
  // FSM, flush counter and output registers
  // --------------------------------------------------------------------------
  retire_state_e            r_state;
  logic [CNT_W-1:0]         r_flush_cnt;

  logic                     r_wr1_en;
  logic [4:0]               r_wr1_idx;
  logic [63:0]              r_wr1_data;
  logic                     r_wr2_en;
  logic [4:0]               r_wr2_idx;
  logic [63:0]              r_wr2_data;
  logic                     r_pht1_en;
  logic [HISTORY_BITS-1:0]  r_pht1_index;
  logic                     r_pht1_taken;
  logic                     r_pht2_en;
  logic [HISTORY_BITS-1:0]  r_pht2_index;
  logic                     r_pht2_taken;
  logic                     r_redirect_valid;
  logic [63:0]              r_redirect_pc;
  logic                     r_flush;
  logic [1:0]               r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state          <= RETIRE_RUN;
      r_flush_cnt      <= '0;
      r_wr1_en         <= 1'b0;
      r_wr1_idx        <= '0;
      r_wr1_data       <= '0;
      r_wr2_en         <= 1'b0;
      r_wr2_idx        <= '0;
      r_wr2_data       <= '0;
      r_pht1_en        <= 1'b0;
      r_pht1_index     <= '0;
      r_pht1_taken     <= 1'b0;
      r_pht2_en        <= 1'b0;
      r_pht2_index     <= '0;
      r_pht2_taken     <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_flush          <= 1'b0;
      r_count          <= '0;
    end else begin
      // Pulses and enables default low; indices/data/redirect_pc hold.
      r_wr1_en         <= 1'b0;
      r_wr2_en         <= 1'b0;
      r_pht1_en        <= 1'b0;
      r_pht2_en        <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_count          <= '0;

      case (r_state)
        RETIRE_RUN: begin
          r_wr1_en  <= w_wr1_en;
          r_wr2_en  <= w_wr2_en;
          r_pht1_en <= w_pht1_en;
          r_pht2_en <= w_pht2_en;
          r_count   <= w_count;

          if (w_wr1_en) begin
            r_wr1_idx  <= inst1_dest_in;
            r_wr1_data <= inst1_value_in;
          end
          if (w_wr2_en) begin
            r_wr2_idx  <= inst2_dest_in;
            r_wr2_data <= inst2_value_in;
          end
          if (w_pht1_en) begin
            r_pht1_index <= inst1_pht_index_in;
            r_pht1_taken <= w_dec1.pht_taken;
          end
          if (w_pht2_en) begin
            r_pht2_index <= inst2_pht_index_in;
            r_pht2_taken <= w_dec2.pht_taken;
          end

          if (w_mispredict) begin
            r_state          <= RETIRE_FLUSH;
            r_flush_cnt      <= FLUSH_LD;
            r_flush          <= 1'b1;
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= w_redirect_pc;
          end else begin
            r_flush <= 1'b0;
          end
        end

        RETIRE_FLUSH: begin
          // Retire ports are ignored for the whole stay in this state.
          if (r_flush_cnt == '0) begin
            r_state <= RETIRE_RUN;
            r_flush <= 1'b0;
          end else begin
            r_flush_cnt <= r_flush_cnt - 1'b1;
            r_flush     <= 1'b1;
          end
        end

        default: begin
          r_state <= RETIRE_RUN;
          r_flush <= 1'b0;
        end
      endcase
    end
  end

  assign wr1_en_out         = r_wr1_en;
  assign wr1_idx_out        = r_wr1_idx;
  assign wr1_data_out       = r_wr1_data;
  assign wr2_en_out         = r_wr2_en;
  assign wr2_idx_out        = r_wr2_idx;
  assign wr2_data_out       = r_wr2_data;
  assign pht1_en_out        = r_pht1_en;
  assign pht1_index_out     = r_pht1_index;
  assign pht1_taken_out     = r_pht1_taken;
  assign pht2_en_out        = r_pht2_en;
  assign pht2_index_out     = r_pht2_index;
  assign pht2_taken_out     = r_pht2_taken;
  assign redirect_valid_out = r_redirect_valid;
  assign redirect_pc_out    = r_redirect_pc;
  assign flush_out          = r_flush;
  assign retired_count_out  = r_count;
  assign dbg_state_out      = r_state;

`ifdef RETIRE_STATS_EN
  // --------------------------------------------------------------------------
  // Statistics: accumulate the registered commit outputs, so each counter
  // trails the cycle whose outputs it counts by one clock.
  // --------------------------------------------------------------------------
  logic [63:0] r_stat_retired;
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispredicts;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stat_retired     <= '0;
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      r_stat_retired     <= r_stat_retired + {62'd0, r_count};
      r_stat_branches    <= r_stat_branches + {31'd0, r_pht1_en} + {31'd0, r_pht2_en};
      r_stat_mispredicts <= r_stat_mispredicts + {31'd0, r_redirect_valid};
    end
  end

  assign stat_retired_out     = r_stat_retired;
  assign stat_branches_out    = r_stat_branches;
  assign stat_mispredicts_out = r_stat_mispredicts;
`endif

endmodule

// File: tb/tb_retire_unit.sv
// ----------------------------------------------------------------------------
// tb_retire_unit
// Drives retire_unit one cycle at a time: inputs change on the falling edge,
// the DUT samples them on the rising edge, outputs are read on the next
// falling edge. A cycle-level reference model of the commit rules produces
// the expected output record for every driven cycle and pushes it to exp_q.
// Build with +define+RETIRE_STATS_EN to also exercise the statistics ports.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_retire_unit;

  localparam int HB = 8;
  localparam int FC = 2;

  typedef struct packed {
    logic [7:0]    tag;
    logic [4:0]    dest;
    logic [63:0]   value;
    logic          mis;
    logic [1:0]    br;
    logic [63:0]   npc;
    logic [HB-1:0] pht;
  } slot_t;

  typedef struct packed {
    logic          wr1_en;
    logic [4:0]    wr1_idx;
    logic [63:0]   wr1_data;
    logic          wr2_en;
    logic [4:0]    wr2_idx;
    logic [63:0]   wr2_data;
    logic          pht1_en;
    logic [HB-1:0] pht1_index;
    logic          pht1_taken;
    logic          pht2_en;
    logic [HB-1:0] pht2_index;
    logic          pht2_taken;
    logic          redirect_valid;
    logic [63:0]   redirect_pc;
    logic          flush;
    logic [1:0]    count;
    logic          state;
  } out_t;

  localparam int W = $bits(out_t);

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // ---------------- DUT signals ----------------
  logic [7:0]    inst1_retire_tag_in, inst2_retire_tag_in;
  logic [4:0]    inst1_dest_in, inst2_dest_in;
  logic [63:0]   inst1_value_in, inst2_value_in;
  logic          inst1_mispredicted_in, inst2_mispredicted_in;
  logic [1:0]    inst1_branch_result_in, inst2_branch_result_in;
  logic [63:0]   inst1_NPC_in, inst2_NPC_in;
  logic [HB-1:0] inst1_pht_index_in, inst2_pht_index_in;

  logic          wr1_en_out, wr2_en_out;
  logic [4:0]    wr1_idx_out, wr2_idx_out;
  logic [63:0]   wr1_data_out, wr2_data_out;
  logic          pht1_en_out, pht2_en_out;
  logic [HB-1:0] pht1_index_out, pht2_index_out;
  logic          pht1_taken_out, pht2_taken_out;
  logic          redirect_valid_out;
  logic [63:0]   redirect_pc_out;
  logic          flush_out;
  logic [1:0]    retired_count_out;
  logic          dbg_state_out;
`ifdef RETIRE_STATS_EN
  logic [63:0]   stat_retired_out;
  logic [31:0]   stat_branches_out;
  logic [31:0]   stat_mispredicts_out;
`endif

  retire_unit #(.HISTORY_BITS(HB), .FLUSH_CYCLES(FC)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .inst1_retire_tag_in    (inst1_retire_tag_in),
    .inst1_dest_in          (inst1_dest_in),
    .inst1_value_in         (inst1_value_in),
    .inst1_mispredicted_in  (inst1_mispredicted_in),
    .inst1_branch_result_in (inst1_branch_result_in),
    .inst1_NPC_in           (inst1_NPC_in),
    .inst1_pht_index_in     (inst1_pht_index_in),
    .inst2_retire_tag_in    (inst2_retire_tag_in),
    .inst2_dest_in          (inst2_dest_in),
    .inst2_value_in         (inst2_value_in),
    .inst2_mispredicted_in  (inst2_mispredicted_in),
    .inst2_branch_result_in (inst2_branch_result_in),
    .inst2_NPC_in           (inst2_NPC_in),
    .inst2_pht_index_in     (inst2_pht_index_in),
    .wr1_en_out             (wr1_en_out),
    .wr1_idx_out            (wr1_idx_out),
    .wr1_data_out           (wr1_data_out),
    .wr2_en_out             (wr2_en_out),
    .wr2_idx_out            (wr2_idx_out),
    .wr2_data_out           (wr2_data_out),
    .pht1_en_out            (pht1_en_out),
    .pht1_index_out         (pht1_index_out),
    .pht1_taken_out         (pht1_taken_out),
    .pht2_en_out            (pht2_en_out),
    .pht2_index_out         (pht2_index_out),
    .pht2_taken_out         (pht2_taken_out),
    .redirect_valid_out     (redirect_valid_out),
    .redirect_pc_out        (redirect_pc_out),
    .flush_out              (flush_out),
    .retired_count_out      (retired_count_out),
`ifdef RETIRE_STATS_EN
    .stat_retired_out       (stat_retired_out),
    .stat_branches_out      (stat_branches_out),
    .stat_mispredicts_out   (stat_mispredicts_out),
`endif
    .dbg_state_out          (dbg_state_out)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           total = 0;
  int           bad   = 0;

  // Reference model state: how many more input samples are swallowed by a
  // flush, and the last redirect target.
  int           m_ignore = 0;
  logic [63:0]  m_pc     = '0;

  function automatic slot_t mk(input logic [7:0] tag, input logic [4:0] dest,
                               input logic [63:0] value, input logic mis,
                               input logic [1:0] br, input logic [63:0] npc,
                               input logic [HB-1:0] pht);
    slot_t s;
    s.tag = tag; s.dest = dest; s.value = value; s.mis = mis;
    s.br = br; s.npc = npc; s.pht = pht;
    return s;
  endfunction

  function automatic slot_t null_slot();
    return mk(8'hFF, 5'd0, 64'd0, 1'b0, 2'b00, 64'd0, '0);
  endfunction

  // Expected outputs for one driven cycle, straight from the commit rules.
  function automatic out_t model_cycle(input slot_t a, input slot_t b);
    out_t e;
    bit   c1, c2, mp, is_br1, is_br2;
    e = '0;
    if (m_ignore > 0) begin
      e.flush       = (m_ignore > 1);
      m_ignore      = m_ignore - 1;
      e.redirect_pc = m_pc;
      e.state       = (m_ignore > 0);
      return e;
    end
    c1 = (a.tag != 8'hFF);
    c2 = c1 && (b.tag != 8'hFF) && !a.mis;
    mp = (c1 && a.mis) || (c2 && b.mis);
    is_br1 = (a.br == 2'b10) || (a.br == 2'b11);
    is_br2 = (b.br == 2'b10) || (b.br == 2'b11);
    if (c2 && b.dest != 0) begin
      e.wr2_en = 1'b1; e.wr2_idx = b.dest; e.wr2_data = b.value;
    end
    if (c1 && a.dest != 0 && !(e.wr2_en && a.dest == b.dest)) begin
      e.wr1_en = 1'b1; e.wr1_idx = a.dest; e.wr1_data = a.value;
    end
    if (c1 && is_br1) begin
      e.pht1_en = 1'b1; e.pht1_index = a.pht; e.pht1_taken = a.br[0];
    end
    if (c2 && is_br2) begin
      e.pht2_en = 1'b1; e.pht2_index = b.pht; e.pht2_taken = b.br[0];
    end
    e.count = 2'(int'(c1) + int'(c2));
    if (mp) begin
      m_pc             = (c1 && a.mis) ? a.npc : b.npc;
      e.redirect_valid = 1'b1;
      e.flush          = 1'b1;
      m_ignore         = FC;
    end
    e.redirect_pc = m_pc;
    e.state       = mp;
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  // Call right after a falling edge: applies a pair of retire ports and
  // queues the model's expectation for the cycle they are sampled in.
  task automatic drive_pair(input slot_t a, input slot_t b);
    inst1_retire_tag_in    = a.tag;   inst2_retire_tag_in    = b.tag;
    inst1_dest_in          = a.dest;  inst2_dest_in          = b.dest;
    inst1_value_in         = a.value; inst2_value_in         = b.value;
    inst1_mispredicted_in  = a.mis;   inst2_mispredicted_in  = b.mis;
    inst1_branch_result_in = a.br;    inst2_branch_result_in = b.br;
    inst1_NPC_in           = a.npc;   inst2_NPC_in           = b.npc;
    inst1_pht_index_in     = a.pht;   inst2_pht_index_in     = b.pht;
    exp_q.push_back(W'(model_cycle(a, b)));
  endtask

  // Captures the outputs; index/data fields of a disabled port are don't-care.
  task automatic read_outputs(output out_t o);
    o.wr1_en = wr1_en_out; o.wr1_idx = wr1_idx_out; o.wr1_data = wr1_data_out;
    o.wr2_en = wr2_en_out; o.wr2_idx = wr2_idx_out; o.wr2_data = wr2_data_out;
    o.pht1_en = pht1_en_out; o.pht1_index = pht1_index_out; o.pht1_taken = pht1_taken_out;
    o.pht2_en = pht2_en_out; o.pht2_index = pht2_index_out; o.pht2_taken = pht2_taken_out;
    o.redirect_valid = redirect_valid_out; o.redirect_pc = redirect_pc_out;
    o.flush = flush_out; o.count = retired_count_out; o.state = dbg_state_out;
    if (o.wr1_en !== 1'b1) begin o.wr1_idx = '0; o.wr1_data = '0; end
    if (o.wr2_en !== 1'b1) begin o.wr2_idx = '0; o.wr2_data = '0; end
    if (o.pht1_en !== 1'b1) begin o.pht1_index = '0; o.pht1_taken = 1'b0; end
    if (o.pht2_en !== 1'b1) begin o.pht2_index = '0; o.pht2_taken = 1'b0; end
  endtask

  task automatic sample_cycle(output out_t o, output out_t e);
    @(negedge clock);
    read_outputs(o);
    if (exp_q.size() == 0) e = 'x;
    else e = out_t'(exp_q.pop_front());
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_pair(null_slot(), null_slot());
    void'(exp_q.pop_back());
    exp_q.delete();
    m_ignore = 0;
    m_pc     = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    out_t o;
    reset = 1'b1;
    #1;
    read_outputs(o);
    total++;
    if (o !== out_t'(0)) begin
      bad++; $display("FAIL reset_state: got %h want %h", o, out_t'(0));
    end
    do_reset();
  endtask

  task automatic test_alu_pair();
    out_t o, e;
    drive_pair(mk(8'd3, 5'd5, 64'hAA, 1'b0, 2'b00, 64'h0, 8'h00),
               mk(8'd4, 5'd6, 64'hBB, 1'b0, 2'b00, 64'h0, 8'h00));
    sample_cycle(o, e);
    total++;
    if (o !== e) begin bad++; $display("FAIL alu_pair: got %h want %h", o, e); end
    total++;
    if ({o.wr1_en, o.wr1_idx, o.wr1_data, o.wr2_en, o.wr2_idx, o.wr2_data} !==
        {1'b1, 5'd5, 64'hAA, 1'b1, 5'd6, 64'hBB}) begin
      bad++; $display("FAIL alu_pair_writes: got wr1=%b/%0d/%h wr2=%b/%0d/%h want 1/5/aa 1/6/bb",
                      o.wr1_en, o.wr1_idx, o.wr1_data, o.wr2_en, o.wr2_idx, o.wr2_data);
    end
    total++;
    if ({o.count, o.pht1_en, o.pht2_en, o.flush} !== {2'd2, 3'b000}) begin
      bad++; $display("FAIL alu_pair_misc: got count=%0d pht=%b%b flush=%b want 2 00 0",
                      o.count, o.pht1_en, o.pht2_en, o.flush);
    end
  endtask

  task automatic test_same_dest();
    out_t o, e;
    drive_pair(mk(8'd20, 5'd7, 64'd1, 1'b0, 2'b10, 64'h0, 8'h11),
               mk(8'd21, 5'd7, 64'd2, 1'b0, 2'b11, 64'h0, 8'h12));
    sample_cycle(o, e);
    total++;
    if (o !== e) begin bad++; $display("FAIL same_dest: got %h want %h", o, e); end
    total++;
    if ({o.wr1_en, o.wr2_en, o.wr2_idx, o.wr2_data, o.count, o.pht1_en, o.pht2_en} !==
        {1'b0, 1'b1, 5'd7, 64'd2, 2'd2, 2'b11}) begin
      bad++; $display("FAIL same_dest_fields: got wr1_en=%b wr2=%b/%0d/%0d count=%0d pht=%b%b want 0 1/7/2 2 11",
                      o.wr1_en, o.wr2_en, o.wr2_idx, o.wr2_data, o.count, o.pht1_en, o.pht2_en);
    end
  endtask

  task automatic test_mispredict_inst1();
    out_t o, e;
    drive_pair(mk(8'd10, 5'd3, 64'h55, 1'b1, 2'b11, 64'h1000, 8'h21),
               mk(8'd11, 5'd9, 64'h66, 1'b0, 2'b00, 64'h0, 8'h00));
    sample_cycle(o, e);
    total++;
    if (o !== e) begin bad++; $display("FAIL mp1_commit: got %h want %h", o, e); end
    total++;
    if ({o.redirect_valid, o.redirect_pc, o.pht1_en, o.pht1_taken, o.wr2_en, o.count, o.flush} !==
        {1'b1, 64'h1000, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1}) begin
      bad++; $display("FAIL mp1_fields: got redir=%b pc=%h pht1=%b/%b wr2=%b count=%0d flush=%b want 1 1000 1/1 0 1 1",
                      o.redirect_valid, o.redirect_pc, o.pht1_en, o.pht1_taken, o.wr2_en, o.count, o.flush);
    end
    // Valid retires presented during the flush window must be dropped.
    for (int i = 0; i < FC; i++) begin
      drive_pair(mk(8'd12 + 8'(i), 5'd4, 64'h77, 1'b0, 2'b10, 64'h0, 8'h30),
                 mk(8'd14 + 8'(i), 5'd8, 64'h88, 1'b0, 2'b00, 64'h0, 8'h00));
      sample_cycle(o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL mp1_flush_%0d: got %h want %h", i, o, e); end
      total++;
      if ({o.wr1_en, o.wr2_en, o.pht1_en, o.redirect_valid, o.count, o.flush} !==
          {4'b0000, 2'd0, (i < FC - 1)}) begin
        bad++; $display("FAIL mp1_flush_fields_%0d: got en=%b%b%b redir=%b count=%0d flush=%b",
                        i, o.wr1_en, o.wr2_en, o.pht1_en, o.redirect_valid, o.count, o.flush);
      end
    end
    drive_pair(mk(8'd16, 5'd4, 64'h99, 1'b0, 2'b00, 64'h0, 8'h00), null_slot());
    sample_cycle(o, e);
    total++;
    if (o !== e) begin bad++; $display("FAIL mp1_resume: got %h want %h", o, e); end
    total++;
    if ({o.wr1_en, o.wr1_data, o.count, o.flush} !== {1'b1, 64'h99, 2'd1, 1'b0}) begin
      bad++; $display("FAIL mp1_resume_fields: got wr1=%b/%h count=%0d flush=%b want 1/99 1 0",
                      o.wr1_en, o.wr1_data, o.count, o.flush);
    end
  endtask

  task automatic test_mispredict_inst2();
    out_t o, e;
    drive_pair(mk(8'd30, 5'd2, 64'h1, 1'b0, 2'b00, 64'h0, 8'h00),
               mk(8'd31, 5'd0, 64'h2, 1'b1, 2'b10, 64'h2040, 8'h44));
    sample_cycle(o, e);
    total++;
    if (o !== e) begin bad++; $display("FAIL mp2_commit: got %h want %h", o, e); end
    total++;
    if ({o.count, o.pht2_en, o.pht2_taken, o.redirect_valid, o.redirect_pc, o.flush} !==
        {2'd2, 1'b1, 1'b0, 1'b1, 64'h2040, 1'b1}) begin
      bad++; $display("FAIL mp2_fields: got count=%0d pht2=%b/%b redir=%b pc=%h flush=%b want 2 1/0 1 2040 1",
                      o.count, o.pht2_en, o.pht2_taken, o.redirect_valid, o.redirect_pc, o.flush);
    end
    for (int i = 0; i < FC; i++) begin
      drive_pair(null_slot(), null_slot());
      sample_cycle(o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL mp2_flush_%0d: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_inst2_only();
    out_t o, e;
    drive_pair(null_slot(), mk(8'd40, 5'd12, 64'hDEAD, 1'b1, 2'b11, 64'h3000, 8'h01));
    sample_cycle(o, e);
    total++;
    if (o !== e) begin bad++; $display("FAIL inst2_only: got %h want %h", o, e); end
    total++;
    if ({o.wr2_en, o.pht2_en, o.count, o.redirect_valid, o.flush} !== {2'b00, 2'd0, 2'b00}) begin
      bad++; $display("FAIL inst2_only_fields: got wr2=%b pht2=%b count=%0d redir=%b flush=%b want all 0",
                      o.wr2_en, o.pht2_en, o.count, o.redirect_valid, o.flush);
    end
  endtask

  function automatic slot_t rand_slot();
    slot_t s;
    s.tag   = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
    s.dest  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
    s.value = {32'($urandom), 32'($urandom)};
    s.mis   = ($urandom_range(0, 9) == 0);
    s.br    = 2'($urandom_range(0, 3));
    s.npc   = {32'($urandom), 32'($urandom)};
    s.pht   = HB'($urandom);
    return s;
  endfunction

  task automatic test_random();
    out_t o, e;
    for (int i = 0; i < 300; i++) begin
      drive_pair(rand_slot(), rand_slot());
      sample_cycle(o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL random_%0d: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_reset_mid_flush();
    out_t o, e;
    drive_pair(mk(8'd50, 5'd1, 64'h5, 1'b1, 2'b10, 64'h4000, 8'h05), null_slot());
    sample_cycle(o, e);
    total++;
    if (o !== e) begin bad++; $display("FAIL rmf_enter: got %h want %h", o, e); end
    drive_pair(mk(8'd51, 5'd2, 64'h6, 1'b0, 2'b00, 64'h0, 8'h00), null_slot());
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    read_outputs(o);
    total++;
    if (o !== out_t'(0)) begin
      bad++; $display("FAIL rmf_async_clear: got %h want %h", o, out_t'(0));
    end
    exp_q.delete();
    m_ignore = 0;
    m_pc     = '0;
    @(negedge clock);
    reset = 1'b0;
    drive_pair(mk(8'd52, 5'd3, 64'h77, 1'b0, 2'b11, 64'h0, 8'h09), null_slot());
    sample_cycle(o, e);
    total++;
    if (o !== e) begin bad++; $display("FAIL rmf_after: got %h want %h", o, e); end
    total++;
    if ({o.wr1_en, o.wr1_idx, o.wr1_data, o.count, o.flush} !== {1'b1, 5'd3, 64'h77, 2'd1, 1'b0}) begin
      bad++; $display("FAIL rmf_after_fields: got wr1=%b/%0d/%h count=%0d flush=%b want 1/3/77 1 0",
                      o.wr1_en, o.wr1_idx, o.wr1_data, o.count, o.flush);
    end
  endtask

`ifdef RETIRE_STATS_EN
  task automatic test_stats();
    out_t o, e;
    do_reset();
    @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      logic [1:0] br;
      br = (i == 2) ? 2'b10 : (i == 5) ? 2'b11 : (i == 8) ? 2'b11 : 2'b00;
      drive_pair(mk(8'(i), 5'(i + 1), 64'(i), (i == 8), br, 64'h5000, 8'(i)), null_slot());
      sample_cycle(o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL stats_step_%0d: got %h want %h", i, o, e); end
      if (i == 8) begin
        for (int j = 0; j < FC; j++) begin
          drive_pair(null_slot(), null_slot());
          sample_cycle(o, e);
        end
      end
    end
    drive_pair(null_slot(), null_slot());
    sample_cycle(o, e);
    drive_pair(null_slot(), null_slot());
    sample_cycle(o, e);
    total++;
    if (stat_retired_out !== 64'd10) begin
      bad++; $display("FAIL stat_retired: got %0d want 10", stat_retired_out);
    end
    total++;
    if (stat_branches_out !== 32'd3) begin
      bad++; $display("FAIL stat_branches: got %0d want 3", stat_branches_out);
    end
    total++;
    if (stat_mispredicts_out !== 32'd1) begin
      bad++; $display("FAIL stat_mispredicts: got %0d want 1", stat_mispredicts_out);
    end
  endtask
`endif

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // ---------------- sequence + report ----------------
  initial begin
    drive_pair(null_slot(), null_slot());
    exp_q.delete();
    test_reset();
    @(negedge clock);
    test_alu_pair();
    test_same_dest();
    test_mispredict_inst1();
    test_mispredict_inst2();
    test_inst2_only();
    test_random();
    test_reset_mid_flush();
`ifdef RETIRE_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
